// File: rtl/load_store_unit_if.sv
// CPU request/response channels, memory-controller data port and perf counters of the load/store unit.
// slave = LSU view, master = environment (CPU + controller) view.
interface load_store_unit_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        i_req_we;
    logic [1:0]  i_req_width;
    logic        i_req_zeroextend;

    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_fault;

    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [1:0]  o_mem_width;
    logic        o_mem_we;
    logic        o_mem_read_en;
    logic        o_mem_zeroextend;
    logic [31:0] i_mem_rdata;

    logic [31:0] o_load_count;
    logic [31:0] o_store_count;
    logic [31:0] o_fault_count;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_wdata, i_req_we, i_req_width, i_req_zeroextend,
        input  i_rsp_ready, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_fault,
        output o_mem_addr, o_mem_wdata, o_mem_width, o_mem_we, o_mem_read_en, o_mem_zeroextend,
        output o_load_count, o_store_count, o_fault_count
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_wdata, i_req_we, i_req_width, i_req_zeroextend,
        output i_rsp_ready, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_fault,
        input  o_mem_addr, o_mem_wdata, o_mem_width, o_mem_we, o_mem_read_en, o_mem_zeroextend,
        input  o_load_count, o_store_count, o_fault_count
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: checks alignment/region, issues one-cycle memory access, returns response.
// Latency: load rsp 3 cycles after accept, store 2, fault 1. One request in flight; rsp held until i_rsp_ready.
// Optional perf counters enabled by LSU_PERF_COUNTERS_EN (ports tied to 0 otherwise).
module load_store_unit #(
    parameter logic [3:0] BROM_BASE = 4'h1,
    parameter logic [3:0] IMEM_BASE = 4'h2,
    parameter logic [3:0] DMEM_BASE = 4'h4,
    parameter logic [3:0] PERI_BASE = 4'h8
) (
    input logic               i_clk,
    input logic               i_rst_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  mem_width_q;
    logic        mem_we_q;
    logic        mem_re_q;
    logic        mem_zx_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_fault_q;

    logic        accept;
    logic        misalign;
    logic        bad_region;
    logic        rom_store;
    logic        req_fault;
    logic [3:0]  nib;

    assign nib        = bus.i_req_addr[31:28];
    assign misalign   = ((bus.i_req_width == 2'd2) && bus.i_req_addr[0]) ||
                        (((bus.i_req_width == 2'd0) || (bus.i_req_width == 2'd3)) &&
                         (bus.i_req_addr[1:0] != 2'b00));
    assign bad_region = (nib != BROM_BASE) && (nib != IMEM_BASE) &&
                        (nib != DMEM_BASE) && (nib != PERI_BASE);
    assign rom_store  = bus.i_req_we && (nib == BROM_BASE);
    assign req_fault  = misalign || bad_region || rom_store;
    assign accept     = bus.i_req_valid && (state_q == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_fault ? RESP : ISSUE;
            ISSUE:   state_d = mem_we_q ? RESP : WAIT;
            WAIT:    state_d = RESP;
            RESP:    if (bus.i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-port fields double as the capture registers: only legal requests
    // load them, so they keep the last issued access while idle or faulting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_width_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_zx_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            if (accept && !req_fault) begin
                mem_addr_q  <= bus.i_req_addr;
                mem_wdata_q <= bus.i_req_wdata;
                mem_width_q <= bus.i_req_width;
                mem_zx_q    <= bus.i_req_zeroextend;
                mem_we_q    <= bus.i_req_we;
                mem_re_q    <= !bus.i_req_we;
            end
            if (accept && req_fault) begin
                rsp_valid_q <= 1'b1;
                rsp_fault_q <= 1'b1;
                rsp_rdata_q <= '0;
            end
            if ((state_q == ISSUE) && mem_we_q) begin
                rsp_valid_q <= 1'b1;
                rsp_fault_q <= 1'b0;
                rsp_rdata_q <= '0;
            end
            if (state_q == WAIT) begin
                rsp_valid_q <= 1'b1;
                rsp_fault_q <= 1'b0;
                rsp_rdata_q <= bus.i_mem_rdata;
            end
            if ((state_q == RESP) && bus.i_rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_req_ready      = (state_q == IDLE);
    assign bus.o_rsp_valid      = rsp_valid_q;
    assign bus.o_rsp_rdata      = rsp_rdata_q;
    assign bus.o_rsp_fault      = rsp_fault_q;
    assign bus.o_mem_addr       = mem_addr_q;
    assign bus.o_mem_wdata      = mem_wdata_q;
    assign bus.o_mem_width      = mem_width_q;
    assign bus.o_mem_we         = mem_we_q;
    assign bus.o_mem_read_en    = mem_re_q;
    assign bus.o_mem_zeroextend = mem_zx_q;

`ifdef LSU_PERF_COUNTERS_EN
    logic [31:0] load_cnt_q;
    logic [31:0] store_cnt_q;
    logic [31:0] fault_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            fault_cnt_q <= '0;
        end else begin
            if ((state_q == ISSUE) && !mem_we_q) load_cnt_q  <= load_cnt_q + 32'd1;
            if ((state_q == ISSUE) && mem_we_q)  store_cnt_q <= store_cnt_q + 32'd1;
            if (accept && req_fault)             fault_cnt_q <= fault_cnt_q + 32'd1;
        end
    end

    assign bus.o_load_count  = load_cnt_q;
    assign bus.o_store_count = store_cnt_q;
    assign bus.o_fault_count = fault_cnt_q;
`else
    assign bus.o_load_count  = '0;
    assign bus.o_store_count = '0;
    assign bus.o_fault_count = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_load_store_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if lsu ();

    load_store_unit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (lsu)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int          t_lat, t_nwe, t_nre, t_recyc;
    logic [31:0] t_addr, t_wdata;
    logic [1:0]  t_width;
    logic        t_zx;

`ifdef LSU_PERF_COUNTERS_EN
    localparam logic [31:0] EXP_LD = 32'd2, EXP_ST = 32'd1, EXP_FLT = 32'd1;
`else
    localparam logic [31:0] EXP_LD = 32'd0, EXP_ST = 32'd0, EXP_FLT = 32'd0;
`endif

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h4000_0010) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    // Controller model: registered read, data valid the cycle after read_en.
    always @(posedge clk) begin
        if (lsu.o_mem_read_en) lsu.i_mem_rdata <= mem_val(lsu.o_mem_addr);
        else                   lsu.i_mem_rdata <= 32'hBAD0_BAD0;
    end

    // Monitor: compares every response handshake against the scoreboard.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && lsu.o_rsp_valid && lsu.i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata %h fault %b, expected no response",
                         lsu.o_rsp_rdata, lsu.o_rsp_fault);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", lsu.o_rsp_rdata, e.rdata);
                check("rsp_fault", 32'(lsu.o_rsp_fault), 32'(e.fault));
            end
        end
    end

    // Issues one request and returns at the negedge where o_rsp_valid first shows.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                          input logic [1:0] width, input logic zx,
                          input logic [31:0] exp_rdata, input logic exp_fault);
        rsp_t e;
        @(negedge clk);
        check("req_ready_idle", 32'(lsu.o_req_ready), 32'd1);
        lsu.i_req_valid      = 1'b1;
        lsu.i_req_addr       = addr;
        lsu.i_req_wdata      = wdata;
        lsu.i_req_we         = we;
        lsu.i_req_width      = width;
        lsu.i_req_zeroextend = zx;
        e.rdata = exp_rdata;
        e.fault = exp_fault;
        exp_q.push_back(e);
        t_lat = 99; t_nwe = 0; t_nre = 0; t_recyc = 0;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) lsu.i_req_valid = 1'b0;
            if (lsu.o_mem_we) begin
                t_nwe++;
                t_addr  = lsu.o_mem_addr;
                t_wdata = lsu.o_mem_wdata;
                t_width = lsu.o_mem_width;
            end
            if (lsu.o_mem_read_en) begin
                t_nre++;
                t_recyc = c;
                t_addr  = lsu.o_mem_addr;
                t_width = lsu.o_mem_width;
                t_zx    = lsu.o_mem_zeroextend;
            end
            if (lsu.o_rsp_valid) begin
                t_lat = c;
                break;
            end
        end
    endtask

    // Response handshake at the next edge, then the LSU must be idle.
    task automatic complete();
        @(posedge clk);
        @(negedge clk);
        check("idle_after_rsp", 32'(lsu.o_req_ready), 32'd1);
        check("rsp_valid_dropped", 32'(lsu.o_rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        lsu.i_req_valid      = 1'b0;
        lsu.i_req_addr       = '0;
        lsu.i_req_wdata      = '0;
        lsu.i_req_we         = 1'b0;
        lsu.i_req_width      = 2'd0;
        lsu.i_req_zeroextend = 1'b0;
        lsu.i_rsp_ready      = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(lsu.o_rsp_valid), 32'd0);
        check("rst_rsp_fault", 32'(lsu.o_rsp_fault), 32'd0);
        check("rst_rsp_rdata", lsu.o_rsp_rdata, 32'd0);
        check("rst_mem_we", 32'(lsu.o_mem_we), 32'd0);
        check("rst_mem_re", 32'(lsu.o_mem_read_en), 32'd0);
        check("rst_mem_addr", lsu.o_mem_addr, 32'd0);
        check("rst_mem_wdata", lsu.o_mem_wdata, 32'd0);
        check("rst_mem_width", 32'(lsu.o_mem_width), 32'd0);
        check("rst_load_cnt", lsu.o_load_count, 32'd0);
        rst_n = 1'b1;
        #1 check("ready_after_release", 32'(lsu.o_req_ready), 32'd1);

        // Word load, DMEM
        do_req(32'h4000_0010, 32'h0, 1'b0, 2'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        check("ld_latency", 32'(t_lat), 32'd3);
        check("ld_re_pulses", 32'(t_nre), 32'd1);
        check("ld_re_cycle", 32'(t_recyc), 32'd1);
        check("ld_we_pulses", 32'(t_nwe), 32'd0);
        check("ld_mem_addr", t_addr, 32'h4000_0010);
        complete();

        // Byte store, peripheral
        do_req(32'h8000_0002, 32'h0000_00A5, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0);
        check("st_latency", 32'(t_lat), 32'd2);
        check("st_we_pulses", 32'(t_nwe), 32'd1);
        check("st_re_pulses", 32'(t_nre), 32'd0);
        check("st_mem_addr", t_addr, 32'h8000_0002);
        check("st_mem_wdata", t_wdata, 32'h0000_00A5);
        check("st_mem_width", 32'(t_width), 32'd1);
        complete();

        // Faults: misaligned half, ROM store, unmapped region, misaligned word
        do_req(32'h4000_0003, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1);
        check("flt_half_latency", 32'(t_lat), 32'd1);
        check("flt_half_mem_pulses", 32'(t_nwe + t_nre), 32'd0);
        check("flt_mem_addr_held", lsu.o_mem_addr, 32'h8000_0002);
        complete();
        do_req(32'h1000_0000, 32'h1234_5678, 1'b1, 2'd0, 1'b0, 32'h0, 1'b1);
        check("flt_rom_latency", 32'(t_lat), 32'd1);
        check("flt_rom_mem_pulses", 32'(t_nwe + t_nre), 32'd0);
        complete();
        do_req(32'h3000_0000, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        check("flt_region_latency", 32'(t_lat), 32'd1);
        check("flt_region_mem_pulses", 32'(t_nwe + t_nre), 32'd0);
        complete();
        do_req(32'h4000_0002, 32'h0, 1'b0, 2'd3, 1'b0, 32'h0, 1'b1);
        check("flt_word_latency", 32'(t_lat), 32'd1);
        complete();

        // Legal ROM load and IMEM half load with zero-extend passed through
        do_req(32'h1000_0004, 32'h0, 1'b0, 2'd0, 1'b0, 32'h4A5A_0004, 1'b0);
        check("rom_ld_latency", 32'(t_lat), 32'd3);
        complete();
        do_req(32'h2000_0006, 32'h0, 1'b0, 2'd2, 1'b1, 32'h7A5A_0006, 1'b0);
        check("half_ld_latency", 32'(t_lat), 32'd3);
        check("half_ld_zx", 32'(t_zx), 32'd1);
        check("half_ld_width", 32'(t_width), 32'd2);
        complete();

        // Response backpressure for 3 cycles
        lsu.i_rsp_ready = 1'b0;
        do_req(32'h4000_0008, 32'h0, 1'b0, 2'd0, 1'b0, 32'h1A5A_0008, 1'b0);
        check("bp_latency", 32'(t_lat), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_rsp_valid", 32'(lsu.o_rsp_valid), 32'd1);
            check("bp_rsp_rdata", lsu.o_rsp_rdata, 32'h1A5A_0008);
            check("bp_req_ready", 32'(lsu.o_req_ready), 32'd0);
        end
        @(posedge clk);
        #1 lsu.i_rsp_ready = 1'b1;
        @(negedge clk);
        complete();

        // Reset during WAIT of a load: dropped without response
        @(negedge clk);
        lsu.i_req_valid = 1'b1;
        lsu.i_req_addr  = 32'h4000_0030;
        lsu.i_req_we    = 1'b0;
        lsu.i_req_width = 2'd0;
        @(posedge clk);
        @(negedge clk);
        lsu.i_req_valid = 1'b0;
        check("rst_case_issue_re", 32'(lsu.o_mem_read_en), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rsp_valid", 32'(lsu.o_rsp_valid), 32'd0);
        check("async_rst_mem_addr", lsu.o_mem_addr, 32'd0);
        check("async_rst_mem_re", 32'(lsu.o_mem_read_en), 32'd0);
        check("async_rst_rsp_rdata", lsu.o_rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release_ready", 32'(lsu.o_req_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (lsu.o_rsp_valid || lsu.o_mem_we || lsu.o_mem_read_en) seen++;
        end
        check("no_activity_after_rst", 32'(seen), 32'd0);

        // Counters: 2 loads, 1 store, 1 misaligned
        do_req(32'h4000_0020, 32'h0, 1'b0, 2'd0, 1'b0, 32'h1A5A_0020, 1'b0);
        complete();
        do_req(32'h4000_0024, 32'h0, 1'b0, 2'd0, 1'b0, 32'h1A5A_0024, 1'b0);
        complete();
        do_req(32'h4000_0028, 32'hCAFE_F00D, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
        complete();
        do_req(32'h4000_0001, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1);
        complete();
        check("load_count", lsu.o_load_count, EXP_LD);
        check("store_count", lsu.o_store_count, EXP_ST);
        check("fault_count", lsu.o_fault_count, EXP_FLT);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute/memory stage and the data port of the memory controller.
- Accepts one load or store at a time over a valid/ready request channel and checks alignment and region legality.
- Drives the controller's data-port signals for exactly one cycle, waits out the controller's one-cycle registered read latency, then returns a response over a valid/ready response channel.
- Illegal accesses never reach memory; they are answered directly with a fault.

Parameters:
- BROM_BASE, 4'h1, top address nibble of boot ROM; stores to it fault.
- IMEM_BASE, 4'h2, top nibble of instruction RAM.
- DMEM_BASE, 4'h4, top nibble of data RAM.
- PERI_BASE, 4'h8, top nibble of peripheral space.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  CPU request valid.
- o_req_ready  out  1  LSU can accept a request.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_width  in  2  1 = byte, 2 = half, 0/3 = word.
- i_req_zeroextend  in  1  load zero-extends when 1.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  CPU accepts response.
- o_rsp_rdata  out  32  load result; 0 for stores and faults.
- o_rsp_fault  out  1  access faulted.
- o_mem_addr  out  32  to controller data address.
- o_mem_wdata  out  32  to controller write data.
- o_mem_width  out  2  to controller width.
- o_mem_we  out  1  to controller write enable.
- o_mem_read_en  out  1  to controller read enable.
- o_mem_zeroextend  out  1  to controller zero-extend.
- i_mem_rdata  in  32  controller read data, valid one cycle after the address is presented.
- o_load_count, o_store_count, o_fault_count  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - state goes to IDLE.
  - o_rsp_valid, o_rsp_fault, o_mem_we and o_mem_read_en go to 0.
  - o_rsp_rdata, o_mem_addr, o_mem_wdata, o_mem_width and o_mem_zeroextend go to 0.
  - Counters go to 0.
- Reset mid-operation: any in-flight request is dropped with no response, and no further write pulse is issued.
- States: IDLE, ISSUE, WAIT, RESP. o_req_ready = (state == IDLE), so it is 1 immediately after reset release.
- IDLE:
  - On i_req_valid && o_req_ready, capture addr, wdata, we, width and zeroextend.
  - Fault if any of the following holds:
    - half access with addr[0] = 1;
    - word access with addr[1:0] != 0;
    - addr[31:28] is not one of the four bases;
    - store with addr[31:28] == BROM_BASE.
  - On fault: go to RESP with fault = 1 and rdata = 0; no memory access.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - o_mem_* driven from the captured registers.
  - o_mem_we = captured we; o_mem_read_en = !we.
  - Store: go to RESP with rdata = 0 and fault = 0.
  - Load: go to WAIT.
- WAIT: register i_mem_rdata into o_rsp_rdata, set fault = 0, go to RESP.
- RESP: o_rsp_valid = 1 and response fields are held stable until i_rsp_ready; then go to IDLE. A new request is not accepted in the same cycle as the response handshake.
- Outside ISSUE: o_mem_we = 0 and o_mem_read_en = 0; o_mem_addr, o_mem_width and o_mem_zeroextend hold their last driven values.
- Latency from request handshake at edge T:
  - load: ISSUE at T+1, rsp_valid at T+3;
  - store: rsp_valid at T+2;
  - fault: rsp_valid at T+1.
- Sign/zero extension and byte-lane placement are performed by the controller; the LSU passes data through unmodified.

Optional Feature:
- Macro LSU_PERF_COUNTERS_EN.
- When defined:
  - o_load_count increments on each non-faulting load entering WAIT.
  - o_store_count increments on each non-faulting store in ISSUE.
  - o_fault_count increments on each faulting request acceptance.
  - Counters wrap from 32'hFFFF_FFFF to 0.
  - Counters are cleared only by reset.
- When undefined: ports are present and tied to 0, and no counter flops are present.

Test Plan:
- Word load from 0x4000_0010, mem returns 0xDEADBEEF in WAIT -> o_mem_read_en high only at T+1; at T+3 o_rsp_valid = 1, rdata = 0xDEADBEEF, fault = 0.
- Byte store 0x0000_00A5 to 0x8000_0002 -> exactly one cycle with o_mem_we = 1, addr 0x8000_0002, width 1, wdata 0xA5; rsp_valid at T+2 with rdata 0.
- Half load from 0x4000_0003 -> o_mem_we and o_mem_read_en never asserted; rsp_valid at T+1 with fault = 1, rdata = 0. Store to 0x1000_0000 and load from 0x3000_0000 both fault the same way.
- Load response with i_rsp_ready held low 3 cycles -> rsp_valid and rdata stable all 3 cycles, o_req_ready = 0 throughout; IDLE the cycle after the handshake.
- Assert i_rst_n low during WAIT of a load -> outputs zero asynchronously; no rsp_valid after release; o_req_ready = 1 on the first cycle after release.
- With LSU_PERF_COUNTERS_EN: 2 loads, 1 store and 1 misaligned access -> counters read 2/1/1; without the macro, all counters read 0.
